alu_pipe: RTL



---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit, eight-opcode ALU with valid/ready on both sides and an iterative shift-add MUL.
// Latency: accept at edge N -> out_valid after edge N+2 (non-MUL) or N+WIDTH+2 (MUL); one op in flight.
// Backpressure: in_ready only in IDLE; the result is held in HOLD until out_ready. Optional macro ALU_SAT_EN saturates ADD/SUB.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  // Counter value after the last partial-product step; that cycle writes the product back.
  localparam logic [CW-1:0] MUL_WB = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2:0]         op_r;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic               borrow;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_carry;

  logic               accept;
  logic               mul_wb;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign mul_wb   = (state == MUL) && (cnt == MUL_WB);
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  // Single-cycle datapath for every opcode except MUL, working on the captured operands.
  always_comb begin
    sum       = {1'b0, a_r} + {1'b0, b_r};
    diff      = a_r - b_r;
    borrow    = (a_r < b_r);
    a_ext     = {{WIDTH{1'b0}}, a_r};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_carry = sum[WIDTH];
`ifdef ALU_SAT_EN
        alu_res = sum[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                             : {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
`else
        alu_res = {{(WIDTH-1){1'b0}}, sum};
`endif
      end
      OP_SUB: begin
        alu_carry = borrow;
`ifdef ALU_SAT_EN
        alu_res = borrow ? '0 : {{WIDTH{1'b0}}, diff};
`else
        alu_res = {{WIDTH{1'b0}}, diff};
`endif
      end
      OP_AND:  alu_res = {{WIDTH{1'b0}}, a_r & b_r};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, a_r | b_r};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_r ^ b_r};
      // Shifts use only the low SHW bits of b; SHL keeps bits shifted past WIDTH.
      OP_SHL:  alu_res = a_ext << b_r[SHW-1:0];
      OP_SHR:  alu_res = a_ext >> b_r[SHW-1:0];
      // MUL never reaches EXEC; its result comes from the shift-add unit.
      OP_MUL:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Control FSM and operand capture; an accept latches a, b and opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= opcode;
            state <= (opcode == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: state <= HOLD;
        MUL:  if (cnt == MUL_WB) state <= HOLD;
        HOLD: if (out_valid && out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shift-add multiplier: WIDTH add/shift steps (cnt 0..WIDTH-1), then one writeback cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if ((state == MUL) && (cnt != MUL_WB)) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result/flag registers and out_valid: loaded when the op completes, presented one cycle later, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == EXEC) begin
        result <= alu_res;
        zero   <= ~|alu_res;
        carry  <= alu_carry;
      end else if (mul_wb) begin
        result <= acc;
        zero   <= ~|acc;
        carry  <= 1'b0;
      end
      if (state == HOLD) begin
        out_valid <= ~(out_valid & out_ready);
      end
    end
  end

endmodule
